div_result_bcd: RTL and testbench



---
 rtl/div_result_bcd_pkg.sv | 27 ++
 rtl/div_result_bcd_if.sv | 31 +++
 rtl/div_result_bcd_dabble.sv | 52 +++++
 rtl/div_result_bcd.sv | 132 +++++++++++++
 tb/tb_div_result_bcd.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/div_result_bcd_pkg.sv
// Shared definitions for the divider result BCD stage.
//   state_t     : controller states (IDLE, CONV, FINISH)
//   NIBBLE_W    : width of one BCD digit
//   bcd_digits  : number of decimal digits needed for a WIDTH-bit unsigned value
package div_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FINISH
  } state_t;

  // Smallest digit count d with 10^d > 2^width - 1.
  function automatic int bcd_digits(input int width);
    longint max_val = (longint'(1) << width) - 1;
    longint lim     = 10;
    int     d       = 1;
    while (lim <= max_val) begin
      d++;
      lim *= 10;
    end
    return d;
  endfunction

endpackage

// File: rtl/div_result_bcd_if.sv
// Bus between the integer divider and the BCD result stage.
//   master : divider side, drives valid_in/dbz_in/q_in/r_in
//   slave  : BCD stage, drives busy/done/err/q_bcd/r_bcd
interface div_result_bcd_if
  import div_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 2
);

  logic                         valid_in;
  logic                         dbz_in;
  logic [WIDTH-1:0]             q_in;
  logic [WIDTH-1:0]             r_in;
  logic                         busy;
  logic                         done;
  logic                         err;
  logic [NIBBLE_W*DIGITS-1:0]   q_bcd;
  logic [NIBBLE_W*DIGITS-1:0]   r_bcd;

  modport master (
    output valid_in, dbz_in, q_in, r_in,
    input  busy, done, err, q_bcd, r_bcd
  );

  modport slave (
    input  valid_in, dbz_in, q_in, r_in,
    output busy, done, err, q_bcd, r_bcd
  );

endinterface

// File: rtl/div_result_bcd_dabble.sv
// Sequential double-dabble converter, one binary bit per step.
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture bin_in and clear the BCD accumulator
//   step     : add-3 to every nibble >= 5, then shift {bcd, bin} left by one
//   bin_in   : binary operand
//   bcd_out  : packed BCD accumulator, digit 0 in bits [3:0]
module bcd_dabble
  import div_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic                       step,
  input  logic [WIDTH-1:0]           bin_in,
  output logic [NIBBLE_W*DIGITS-1:0] bcd_out
);

  localparam int BCD_W = NIBBLE_W * DIGITS;

  logic [BCD_W-1:0] bcd;
  logic [BCD_W-1:0] bcd_adj;
  logic [WIDTH-1:0] bin;

  // Nibbles >= 5 would reach >= 10 after the shift, so pre-correct by +3.
  always_comb begin
    // NOTE: assigning the default first keeps this purely combinational (no latch).
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[i*NIBBLE_W +: NIBBLE_W] >= 4'd5)
        bcd_adj[i*NIBBLE_W +: NIBBLE_W] = bcd[i*NIBBLE_W +: NIBBLE_W] + 4'd3;
    end
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd <= '0;
      bin <= '0;
    end else if (load) begin
      bcd <= '0;
      bin <= bin_in;
    end else if (step) begin
      {bcd, bin} <= {bcd_adj, bin} << 1;
    end
  end

  assign bcd_out = bcd;

endmodule

// File: rtl/div_result_bcd.sv
// Converts the divider's quotient and remainder to packed BCD for the
// 7-segment display driver. A rising edge on valid_in starts a WIDTH-step
// double-dabble conversion of both operands; a rising edge on dbz_in clears
// the results and flags err. Results are held until the next done pulse.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of div_result_bcd_if
//              (valid_in, dbz_in, q_in, r_in -> busy, done, err, q_bcd, r_bcd)
module div_result_bcd
  import div_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 2
) (
  input logic             clk,
  input logic             rst,
  div_result_bcd_if.slave bus
);

  localparam int BCD_W = NIBBLE_W * DIGITS;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  generate
    if (DIGITS < bcd_digits(WIDTH)) begin : g_bad_digits
      $error("div_result_bcd: DIGITS too small to hold 2^WIDTH-1");
    end
  endgenerate

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             valid_d, dbz_d;
  logic             valid_edge, dbz_edge;
  logic             load, step, fin_upd, dbz_upd;
  logic [BCD_W-1:0] q_dab, r_dab;
  logic [BCD_W-1:0] q_bcd_r, r_bcd_r;
  logic             err_r, done_r;

  // Edge registers track the inputs in every state, so edges seen while busy
  // are consumed rather than replayed once the controller returns to IDLE.
  assign valid_edge = bus.valid_in & ~valid_d;
  assign dbz_edge   = bus.dbz_in   & ~dbz_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      valid_d <= 1'b0;
      dbz_d   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      valid_d <= bus.valid_in;
      dbz_d   <= bus.dbz_in;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    step      = 1'b0;
    fin_upd   = 1'b0;
    dbz_upd   = 1'b0;
    case (state)
      IDLE: begin
        if (dbz_edge) begin
          dbz_upd = 1'b1;
        end else if (valid_edge) begin
          load      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = CONV;
        end
      end
      CONV: begin
        step    = 1'b1;
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) state_nxt = FINISH;
      end
      FINISH: begin
        fin_upd   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  bcd_dabble #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_q_dabble (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .bin_in  (bus.q_in),
    .bcd_out (q_dab)
  );

  bcd_dabble #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_r_dabble (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .bin_in  (bus.r_in),
    .bcd_out (r_dab)
  );

  // Visible outputs move only together with the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_bcd_r <= '0;
      r_bcd_r <= '0;
      err_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= fin_upd | dbz_upd;
      if (dbz_upd) begin
        q_bcd_r <= '0;
        r_bcd_r <= '0;
        err_r   <= 1'b1;
      end else if (fin_upd) begin
        q_bcd_r <= q_dab;
        r_bcd_r <= r_dab;
        err_r   <= 1'b0;
      end
    end
  end

  assign bus.busy  = (state == CONV);
  assign bus.done  = done_r;
  assign bus.err   = err_r;
  assign bus.q_bcd = q_bcd_r;
  assign bus.r_bcd = r_bcd_r;

endmodule

// File: tb/tb_div_result_bcd.sv
// Self-checking bench for div_result_bcd: a WIDTH=4/DIGITS=2 and a
// WIDTH=8/DIGITS=3 instance share the clock and reset; sel routes the
// stimulus to one of them and muxes its outputs for checking.
module tb_div_result_bcd;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_result_bcd_if #(.WIDTH(4), .DIGITS(2)) if4 ();
  div_result_bcd_if #(.WIDTH(8), .DIGITS(3)) if8 ();

  div_result_bcd #(.WIDTH(4), .DIGITS(2)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
  div_result_bcd #(.WIDTH(8), .DIGITS(3)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

  logic       sel;
  logic       valid, dbz;
  logic [7:0] q_in, r_in;

  assign if4.valid_in = valid & ~sel;
  assign if4.dbz_in   = dbz & ~sel;
  assign if4.q_in     = q_in[3:0];
  assign if4.r_in     = r_in[3:0];
  assign if8.valid_in = valid & sel;
  assign if8.dbz_in   = dbz & sel;
  assign if8.q_in     = q_in;
  assign if8.r_in     = r_in;

  logic        obs_busy, obs_done, obs_err;
  logic [11:0] obs_q, obs_r;

  always_comb begin
    if (sel) begin
      obs_busy = if8.busy;
      obs_done = if8.done;
      obs_err  = if8.err;
      obs_q    = if8.q_bcd;
      obs_r    = if8.r_bcd;
    end else begin
      obs_busy = if4.busy;
      obs_done = if4.done;
      obs_err  = if4.err;
      obs_q    = {4'h0, if4.q_bcd};
      obs_r    = {4'h0, if4.r_bcd};
    end
  end

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q[2];
  logic [11:0] exp_r[2];
  logic        exp_err[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (sel=%0d, t=%0t): got %0h, expected %0h", tag, sel, $time, got, exp);
    end
  endtask

  // Decimal digits by plain division.
  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] res = '0;
    int p = 1;
    for (int i = 0; i < 3; i++) begin
      res[4*i +: 4] = 4'((v / p) % 10);
      p *= 10;
    end
    return res;
  endfunction

  // kind: 0 = valid_in rises, 1 = dbz_in rises, 2 = both rise together.
  // hold: negedge on which the raised input(s) drop again.
  // disturb: toggle valid_in and change operands while converting.
  task automatic run_event(input int kind, input int qv, input int rv,
                           input bit disturb, input int hold);
    int w        = sel ? 8 : 4;
    int idx      = sel ? 1 : 0;
    int exp_n;
    int len;
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at  = 0;
    logic [11:0] old_q = exp_q[idx];

    q_in  = 8'(qv);
    r_in  = 8'(rv);
    valid = (kind != 1);
    dbz   = (kind != 0);
    if (kind == 0) begin
      exp_n        = w + 2;
      exp_q[idx]   = to_bcd(qv);
      exp_r[idx]   = to_bcd(rv);
      exp_err[idx] = 1'b0;
    end else begin
      exp_n        = 1;
      exp_q[idx]   = '0;
      exp_r[idx]   = '0;
      exp_err[idx] = 1'b1;
    end
    len = ((exp_n > hold) ? exp_n : hold) + 3;

    for (int n = 1; n <= len; n++) begin
      @(negedge clk);
      if (obs_busy) busy_cnt++;
      if (obs_done) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
        check("q_bcd", obs_q, exp_q[idx]);
        check("r_bcd", obs_r, exp_r[idx]);
        check("err", obs_err, exp_err[idx]);
      end else if (n == 1 && kind == 0) begin
        check("q_hold", obs_q, old_q);
      end
      if (n == hold) begin
        valid = 1'b0;
        dbz   = 1'b0;
      end
      if (disturb && kind == 0 && n <= w) begin
        q_in  = 8'($urandom);
        r_in  = 8'($urandom);
        valid = 1'($urandom);
      end
    end
    valid = 1'b0;
    dbz   = 1'b0;
    @(negedge clk);
    check("done_count", done_cnt, 1);
    check("latency", done_at, exp_n);
    check("busy_cycles", busy_cnt, (kind == 0) ? w : 0);
    check("q_held", obs_q, exp_q[idx]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_at;
    rst   = 1'b1;
    sel   = 1'b0;
    valid = 1'b0;
    dbz   = 1'b0;
    q_in  = '0;
    r_in  = '0;
    for (int i = 0; i < 2; i++) begin
      exp_q[i]   = '0;
      exp_r[i]   = '0;
      exp_err[i] = 1'b0;
    end
    repeat (3) @(negedge clk);

    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      check("rst_busy", obs_busy, 0);
      check("rst_done", obs_done, 0);
      check("rst_err", obs_err, 0);
      check("rst_q", obs_q, 0);
      check("rst_r", obs_r, 0);
    end
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases on the 4-bit instance.
    run_event(0, 6, 1, 1'b0, 1);
    run_event(1, 0, 0, 1'b0, 2);
    run_event(0, 15, 0, 1'b0, 1);
    run_event(0, 7, 3, 1'b0, 20);
    run_event(0, 11, 9, 1'b1, 1);
    run_event(2, 5, 5, 1'b0, 4);

    // Directed cases on the 8-bit instance.
    sel = 1'b1;
    run_event(0, 255, 0, 1'b0, 1);
    run_event(0, 25, 5, 1'b0, 2);
    run_event(1, 0, 0, 1'b0, 1);

    // Randomized mix of events on both instances.
    for (int k = 0; k < 40; k++) begin
      int kind;
      int w;
      sel  = 1'($urandom);
      w    = sel ? 8 : 4;
      kind = ($urandom_range(0, 5) < 4) ? 0 : int'($urandom_range(1, 2));
      run_event(kind, int'($urandom_range(0, (1 << w) - 1)),
                int'($urandom_range(0, (1 << w) - 1)),
                1'($urandom), int'($urandom_range(1, w + 4)));
    end

    // Reset in the middle of a conversion, released with valid_in still high.
    sel = 1'b0;
    run_event(0, 6, 1, 1'b0, 1);
    q_in  = 8'd13;
    r_in  = 8'd2;
    valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("busy_before_rst", obs_busy, 1);
    rst = 1'b1;
    #1;
    check("arst_busy", obs_busy, 0);
    check("arst_done", obs_done, 0);
    check("arst_err", obs_err, 0);
    check("arst_q", obs_q, 0);
    check("arst_r", obs_r, 0);
    q_in = 8'd9;
    r_in = 8'd0;
    @(negedge clk);
    rst     = 1'b0;
    done_at = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (obs_done && done_at == 0) begin
        done_at = n;
        check("post_rst_q", obs_q, 12'h009);
        check("post_rst_r", obs_r, 12'h000);
        check("post_rst_err", obs_err, 0);
      end
    end
    check("post_rst_latency", done_at, 6);
    valid = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
